// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration for a single shared WIDTH-bit register.
// Optional hold limit on a grant: define SRA_HOLD_TIMEOUT_EN.
module shared_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8,
    localparam int OWNER_W = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr_en,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    q_valid,
    output logic [OWNER_W-1:0]      q_owner,
    output logic                    timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic                   q_valid_q, q_valid_d;
    logic [OWNER_W-1:0]     q_owner_q, q_owner_d;

    logic [OWNER_W-1:0]     cand_idx [NREQ];
    logic [OWNER_W-1:0]     pick_idx;
    logic [OWNER_W-1:0]     next_ptr;
    logic [WIDTH-1:0]       owner_lane;
    logic                   wr_hit;
    logic                   limit_hit;
    logic                   release_evt;

    // cand_idx[k] is the requester k places after the pointer, wrapping at NREQ.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [OWNER_W:0] sum;
            assign sum = {1'b0, ptr_q} + (OWNER_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (OWNER_W+1)'(NREQ))
                                ? OWNER_W'(sum - (OWNER_W+1)'(NREQ))
                                : sum[OWNER_W-1:0];
        end
    endgenerate

    always_comb begin
        pick_idx = cand_idx[0];
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    assign owner_lane  = wdata[owner_q*WIDTH +: WIDTH];
    assign wr_hit      = |(gnt_q & wr_en);
    assign next_ptr    = (owner_q == OWNER_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign release_evt = (state_q == GRANT) && (!req[owner_q] || limit_hit);

`ifdef SRA_HOLD_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    // hold_q counts completed grant cycles beyond the first one.
    assign limit_hit = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            hold_d = 8'd0;
        end else if (release_evt) begin
            hold_d    = 8'd0;
            timeout_d = limit_hit && req[owner_q];
        end else begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // MAX_HOLD only matters when the hold limit is compiled in.
    logic unused_max_hold;
    assign unused_max_hold = ^8'(MAX_HOLD);
    assign limit_hit       = 1'b0;
    assign timeout         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        q_owner_d = q_owner_q;

        // A write lands whenever the lane was granted this cycle, even on release.
        if (wr_hit) begin
            q_d       = owner_lane;
            q_owner_d = owner_q;
            q_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d         = GRANT;
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            GRANT: begin
                if (release_evt) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_owner_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_owner_q <= q_owner_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_owner = q_owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random
// traffic against a behavioural owner/pointer model.
module tb_shared_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 8;
    localparam int OW       = $clog2(NREQ);

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      wr_en;
    logic [NREQ*W-1:0]    wdata;
    logic [NREQ-1:0]      gnt;
    logic [W-1:0]         q;
    logic                 q_valid;
    logic [OW-1:0]        q_owner;
    logic                 timeout;

    int n_checks = 0;
    int n_fail   = 0;

    shared_reg_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_owner (q_owner),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner is -1 while nobody holds the register.
    int         m_owner;
    int         m_ptr;
    int         m_held;
    logic [W-1:0] m_q;
    bit         m_valid;
    int         m_qown;
    bit         m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_q     = '0;
        m_valid = 1'b0;
        m_qown  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        bit lim;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            lim = 1'b0;
`ifdef SRA_HOLD_TIMEOUT_EN
            lim = (m_held >= MAX_HOLD);
`endif
            if (wr_en[m_owner]) begin
                m_q     = wdata[m_owner*W +: W];
                m_valid = 1'b1;
                m_qown  = m_owner;
            end
            if (!req[m_owner] || lim) begin
                m_to    = lim && req[m_owner];
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_held  = 1;
                end
            end
        end
    endtask

    // Inputs are stable around posedge; model advances there, outputs compared at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_gnt;
        if (rst_n) begin
            exp_gnt = '0;
            if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("q", 32'(q), 32'(m_q));
            check("q_valid", 32'(q_valid), 32'(m_valid));
            check("q_owner", 32'(q_owner), 32'(m_qown));
            check("timeout", 32'(timeout), 32'(m_to));
        end
    end

    initial begin
        int order [5];
        int exp_order [5];
        int n_rec;
        int held;
        int last_idx;
        logic [NREQ-1:0] g_log [16];
        logic            t_log [16];
        int              g0_cycles;

        exp_order = '{0, 1, 2, 3, 0};
        req   = '0;
        wr_en = '0;
        wdata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_q", 32'(q), 32'h0);
            check("idle_q_valid", 32'(q_valid), 32'h0);
            check("idle_q_owner", 32'(q_owner), 32'h0);
        end
        $display("reset idle: gnt=%b q=%h q_valid=%b", gnt, q, q_valid);

        // Single requester, grant latency and write
        req = 4'b0100;
        tick();
        check("lat_gnt", 32'(gnt), 32'h4);
        wr_en = 4'b0100;
        wdata[2*W +: W] = 8'hA5;
        tick();
        wr_en = '0;
        check("wr_q", 32'(q), 32'hA5);
        check("wr_q_owner", 32'(q_owner), 32'h2);
        check("wr_q_valid", 32'(q_valid), 32'h1);
        $display("write lane2: gnt=%b q=%h owner=%0d", gnt, q, q_owner);
        req = '0;
        tick();

        // Round-robin order with each owner holding three cycles
        do_reset();
        req = 4'b1111;
        n_rec = 0;
        held = 0;
        last_idx = -1;
        for (int c = 0; c < 200 && n_rec < 5; c++) begin
            tick();
            if (gnt != '0) begin
                if (onehot_idx(gnt) != last_idx) begin
                    order[n_rec] = onehot_idx(gnt);
                    $display("grant %0d -> requester %0d", n_rec, order[n_rec]);
                    n_rec++;
                    held = 1;
                end else begin
                    held++;
                end
                last_idx = onehot_idx(gnt);
                if (held == 3) req[last_idx] = 1'b0;
            end else begin
                last_idx = -1;
                req = 4'b1111;
            end
        end
        check("rr_count", 32'(n_rec), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_rec) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
        end

        // Non-owner write ignored, owner write lands
        req = '0;
        repeat (3) tick();
        req = 4'b0010;
        tick();
        check("own1_gnt", 32'(gnt), 32'h2);
        wr_en = 4'b0010;
        wdata[1*W +: W] = 8'h11;
        tick();
        wr_en = 4'b1000;
        wdata[3*W +: W] = 8'h3C;
        wdata[1*W +: W] = 8'h77;
        tick();
        check("foreign_q", 32'(q), 32'h11);
        check("foreign_owner", 32'(q_owner), 32'h1);
        wr_en = 4'b0010;
        wdata[1*W +: W] = 8'h5A;
        tick();
        wr_en = '0;
        check("own_q", 32'(q), 32'h5A);
        check("own_owner", 32'(q_owner), 32'h1);
        $display("owner1 write: q=%h owner=%0d", q, q_owner);

        // Asynchronous reset in the middle of a grant
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_gnt", 32'(gnt), 32'h0);
        check("areset_q", 32'(q), 32'h0);
        check("areset_q_valid", 32'(q_valid), 32'h0);
        $display("async reset: gnt=%b q=%h q_valid=%b", gnt, q, q_valid);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(5) == 0) req[b] = ~req[b];
            end
            wr_en = NREQ'($urandom);
            wdata = (NREQ*W)'($urandom);
            tick();
        end
        $display("random phase: %0d cycles", 2000);

`ifdef SRA_HOLD_TIMEOUT_EN
        // Hold limit revokes a continuously held grant
        req = '0;
        wr_en = '0;
        do_reset();
        req = 4'b0011;
        g0_cycles = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            g_log[c] = gnt;
            t_log[c] = timeout;
            if (c < 9 && gnt[0]) g0_cycles++;
        end
        check("hold_cycles", 32'(g0_cycles), 32'(MAX_HOLD));
        check("hold_timeout", 32'(t_log[8]), 32'h1);
        check("hold_bubble", 32'(g_log[8]), 32'h0);
        check("hold_next_gnt", 32'(g_log[9]), 32'h2);
        $display("hold limit: gnt0 cycles=%0d", g0_cycles);
`else
        g_log[0] = '0;
        t_log[0] = 1'b0;
        g0_cycles = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
